// File: rtl/rf_edge_conditioner.sv
// Synchronises, deglitches and qualifies the asynchronous RF detector line into a
// one-cycle rfin pulse with holdoff and re-arm. Optional event counter: RFC_EVT_CNT_EN.
module rf_edge_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int HOLDOFF     = 10000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf_raw,
    input  logic             enable,
    output logic             rfin,
    output logic             rf_level,
    output logic             busy,
    output logic             miss
`ifdef RFC_EVT_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] evt_cnt
`endif
);
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLDOFF - 1);

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || HOLDOFF < 1 || CNT_W < 1) begin : g_bad_params
        $error("rf_edge_conditioner: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, PULSE, HOLD, REARM} state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   s;
    logic [FC_W-1:0]        fc;
    logic                   level_d;
    state_t                 state;
    state_t                 state_nxt;
    logic [HC_W-1:0]        hcnt;
    logic [HC_W-1:0]        hcnt_nxt;
    logic                   rfin_nxt;
    logic                   miss_nxt;

    assign s    = sync_chain[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    // Synchroniser and consecutive-sample filter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain <= '0;
            fc         <= '0;
            rf_level   <= 1'b0;
            level_d    <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], rf_raw};
            level_d    <= rf_level;
            if (s == rf_level) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                rf_level <= s;
                fc       <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    // Event qualification FSM
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        rfin_nxt  = 1'b0;
        miss_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rf_level && enable) begin
                    state_nxt = PULSE;
                    rfin_nxt  = 1'b1;
                end
            end
            PULSE: begin
                state_nxt = HOLD;
                hcnt_nxt  = HC_LOAD;
            end
            HOLD: begin
                miss_nxt = rf_level && !level_d;
                if (hcnt == '0) begin
                    state_nxt = REARM;
                end else begin
                    hcnt_nxt = hcnt - 1'b1;
                end
            end
            REARM: begin
                if (!rf_level) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            rfin  <= 1'b0;
            miss  <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            rfin  <= rfin_nxt;
            miss  <= miss_nxt;
        end
    end

`ifdef RFC_EVT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Clear wins over a coincident pulse
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            evt_cnt <= '0;
        end else if (rfin) begin
            evt_cnt <= sat_inc(evt_cnt);
        end
    end
`endif

endmodule
